// File: rtl/ep_arb_pkg.sv
// Shared types and TRN bus widths for the endpoint tx arbiter.
package ep_arb_pkg;

   localparam int TD_W    = 64;
   localparam int REM_W   = 8;
   localparam int NCH_MAX = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      BUSY  = 2'd2,
      GAP   = 2'd3
   } arb_state_e;

endpackage

// File: rtl/ep_arb_if.sv
// Channel-side TRN handshake/bus and merged core-side TRN tx bus.
interface ep_arb_if import ep_arb_pkg::*; #(
   parameter int NCH = 2
) ();

   logic [NCH-1:0]             chn_reqep;
   logic [NCH-1:0]             chn_drvn;
   logic [NCH-1:0]             chn_trn;
   logic [NCH-1:0][TD_W-1:0]   chn_trn_td;
   logic [NCH-1:0][REM_W-1:0]  chn_trn_trem_n;
   logic [NCH-1:0]             chn_trn_tsof_n;
   logic [NCH-1:0]             chn_trn_teof_n;
   logic [NCH-1:0]             chn_trn_tsrc_rdy_n;

   logic [TD_W-1:0]            trn_td;
   logic [REM_W-1:0]           trn_trem_n;
   logic                       trn_tsof_n;
   logic                       trn_teof_n;
   logic                       trn_tsrc_rdy_n;

   // Arbiter side: takes channel requests/buses, drives grants and merged bus.
   modport slave (
      input  chn_reqep, chn_drvn, chn_trn_td, chn_trn_trem_n,
             chn_trn_tsof_n, chn_trn_teof_n, chn_trn_tsrc_rdy_n,
      output chn_trn, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n
   );

   // Channel/core side.
   modport master (
      output chn_reqep, chn_drvn, chn_trn_td, chn_trn_trem_n,
             chn_trn_tsof_n, chn_trn_teof_n, chn_trn_tsrc_rdy_n,
      input  chn_trn, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n
   );

endinterface

// File: rtl/ep_arb_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick #(
   parameter int NCH   = 2,
   parameter int IDX_W = 1
) (
   input  logic [NCH-1:0]   req,
   input  logic [IDX_W-1:0] last,
   output logic [NCH-1:0]   gnt_oh,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             vld
);

   logic [IDX_W-1:0] k;

   // Scan last+1 .. last+NCH (mod NCH); the first hit wins.
   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      vld     = 1'b0;
      k       = '0;
      for (int i = 1; i <= NCH; i++) begin
         k = IDX_W'((int'(last) + i) % NCH);
         if (!vld && req[k]) begin
            vld        = 1'b1;
            gnt_idx    = k;
            gnt_oh[k]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ep_arb.sv
// Endpoint TRN tx arbiter: round-robin grant FSM with unused-grant timeout,
// OR/AND merge of the channel buses, and drive-violation detection.
module ep_arb import ep_arb_pkg::*; #(
   parameter  int NCH   = 2,
   parameter  int TO_W  = 4,
   localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   ep_arb_if.slave          bus,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             timeout_err,
   output logic             viol_err
);

   arb_state_e       state;
   logic [IDX_W-1:0] last;
   logic [TO_W-1:0]  cnt;
   logic [NCH-1:0]   pick_oh;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_vld;
   logic [NCH-1:0]   allowed;

   rr_pick #(.NCH(NCH), .IDX_W(IDX_W)) u_pick (
      .req     (bus.chn_reqep),
      .last    (last),
      .gnt_oh  (pick_oh),
      .gnt_idx (pick_idx),
      .vld     (pick_vld)
   );

   // Grant FSM; chn_trn drops on the edge into GAP so grants never overlap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         bus.chn_trn <= '0;
         gnt_idx     <= '0;
         last        <= IDX_W'(NCH - 1);
         cnt         <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pick_vld) begin
                  bus.chn_trn <= pick_oh;
                  gnt_idx     <= pick_idx;
                  last        <= pick_idx;
                  cnt         <= '0;
                  state       <= GRANT;
               end
            end
            GRANT: begin
               if (bus.chn_drvn[gnt_idx]) begin
                  state <= BUSY;
               end else if (!bus.chn_reqep[gnt_idx]) begin
                  bus.chn_trn <= '0;
                  state       <= GAP;
               end else if (cnt == '1) begin
                  bus.chn_trn <= '0;
                  timeout_err <= 1'b1;
                  state       <= GAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BUSY: begin
               if (!bus.chn_drvn[gnt_idx]) begin
                  bus.chn_trn <= '0;
                  state       <= GAP;
               end
            end
            GAP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Merge: idle channels present td=0 and all-ones on active-low strobes.
   always_comb begin
      bus.trn_td         = '0;
      bus.trn_trem_n     = '1;
      bus.trn_tsof_n     = 1'b1;
      bus.trn_teof_n     = 1'b1;
      bus.trn_tsrc_rdy_n = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         bus.trn_td         = bus.trn_td | bus.chn_trn_td[i];
         bus.trn_trem_n     = bus.trn_trem_n & bus.chn_trn_trem_n[i];
         bus.trn_tsof_n     = bus.trn_tsof_n & bus.chn_trn_tsof_n[i];
         bus.trn_teof_n     = bus.trn_teof_n & bus.chn_trn_teof_n[i];
         bus.trn_tsrc_rdy_n = bus.trn_tsrc_rdy_n & bus.chn_trn_tsrc_rdy_n[i];
      end
   end

   // Violation: drvn outside the grant; the last owner may still drive in GAP.
   always_comb begin
      allowed = bus.chn_trn;
      if (state == GAP) allowed[gnt_idx] = 1'b1;
      viol_err = |(bus.chn_drvn & ~allowed);
   end

endmodule

// File: tb/tb_ep_arb.sv
// Self-checking bench for ep_arb: directed scenarios plus randomized grant
// episodes checked against a transaction-level round-robin model.
module tb_ep_arb;
   import ep_arb_pkg::*;

   localparam int NCH   = 2;
   localparam int TO_W  = 4;
   localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int TO_CYC = 2 ** TO_W;

   logic             clk;
   logic             rst_n;
   logic [IDX_W-1:0] gnt_idx;
   logic             timeout_err;
   logic             viol_err;

   int n_tests;
   int n_fail;
   int exp_last;

   ep_arb_if #(.NCH(NCH)) bus ();

   ep_arb #(.NCH(NCH), .TO_W(TO_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .gnt_idx     (gnt_idx),
      .timeout_err (timeout_err),
      .viol_err    (viol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference rule: first requester after the previous winner, wrapping.
   function automatic int model_pick(input logic [NCH-1:0] req, input int last);
      for (int i = 1; i <= NCH; i++)
         if (req[(last + i) % NCH]) return (last + i) % NCH;
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      for (int i = 0; i < NCH; i++) begin
         bus.chn_trn_td[i]         = '0;
         bus.chn_trn_trem_n[i]     = '1;
         bus.chn_trn_tsof_n[i]     = 1'b1;
         bus.chn_trn_teof_n[i]     = 1'b1;
         bus.chn_trn_tsrc_rdy_n[i] = 1'b1;
      end
   endtask

   task automatic drop_all();
      bus.chn_reqep = '0;
      bus.chn_drvn  = '0;
      repeat (3) tick();
   endtask

   task automatic wait_gnt(input int budget, output int cyc);
      cyc = 0;
      while (bus.chn_trn == '0 && cyc < budget) begin
         tick();
         cyc++;
      end
   endtask

   task automatic wait_drop(input int budget, output int cyc);
      cyc = 0;
      while (bus.chn_trn != '0 && cyc < budget) begin
         tick();
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.chn_reqep = '0;
      bus.chn_drvn  = '0;
      idle_bus();
      repeat (2) tick();
      n_tests++;
      if (bus.chn_trn !== '0 || gnt_idx !== '0 || timeout_err !== 1'b0 || viol_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: trn=%b idx=%0d to=%b viol=%b, want 0/0/0/0",
                  bus.chn_trn, gnt_idx, timeout_err, viol_err);
      end
      n_tests++;
      if ({bus.trn_td, bus.trn_trem_n, bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n}
          !== {64'h0, 8'hFF, 3'b111}) begin
         n_fail++;
         $display("FAIL reset_merge: td=%h rem=%h, want idle bus", bus.trn_td, bus.trn_trem_n);
      end
      rst_n = 1'b1;
      tick();
      exp_last = NCH - 1;
   endtask

   task automatic test_basic();
      bus.chn_reqep = 2'b11;
      tick();
      n_tests++;
      if (bus.chn_trn !== 2'b01 || gnt_idx !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_first: trn=%b idx=%0d, want 01/0", bus.chn_trn, gnt_idx);
      end
      bus.chn_drvn = 2'b01;
      repeat (2) tick();
      n_tests++;
      if (bus.chn_trn !== 2'b01) begin
         n_fail++;
         $display("FAIL basic_busy: trn=%b, want 01", bus.chn_trn);
      end
      bus.chn_drvn  = 2'b00;
      bus.chn_reqep = 2'b10;
      tick();
      n_tests++;
      if (bus.chn_trn !== 2'b00) begin
         n_fail++;
         $display("FAIL basic_gap: trn=%b, want 00", bus.chn_trn);
      end
      tick();
      n_tests++;
      if (bus.chn_trn !== 2'b00) begin
         n_fail++;
         $display("FAIL basic_idle: trn=%b, want 00", bus.chn_trn);
      end
      tick();
      n_tests++;
      if (bus.chn_trn !== 2'b10 || gnt_idx !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_second: trn=%b idx=%0d, want 10/1", bus.chn_trn, gnt_idx);
      end
      drop_all();
      exp_last = 1;
   endtask

   task automatic test_timeout();
      int bad;
      bus.chn_reqep = 2'b10;
      tick();
      n_tests++;
      if (bus.chn_trn !== 2'b10) begin
         n_fail++;
         $display("FAIL to_grant: trn=%b, want 10", bus.chn_trn);
      end
      bad = 0;
      for (int i = 1; i < TO_CYC; i++) begin
         tick();
         if (bus.chn_trn !== 2'b10 || timeout_err !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL to_hold: %0d early drops/pulses, want 0", bad);
      end
      tick();
      n_tests++;
      if (timeout_err !== 1'b1 || bus.chn_trn !== 2'b00) begin
         n_fail++;
         $display("FAIL to_pulse: to=%b trn=%b, want 1/00", timeout_err, bus.chn_trn);
      end
      tick();
      n_tests++;
      if (timeout_err !== 1'b0 || bus.chn_trn !== 2'b00) begin
         n_fail++;
         $display("FAIL to_single: to=%b trn=%b, want 0/00", timeout_err, bus.chn_trn);
      end
      tick();
      n_tests++;
      if (bus.chn_trn !== 2'b10 || gnt_idx !== 1'b1) begin
         n_fail++;
         $display("FAIL to_regrant: trn=%b idx=%0d, want 10/1", bus.chn_trn, gnt_idx);
      end
      drop_all();
      exp_last = 1;
   endtask

   task automatic test_withdraw();
      bus.chn_reqep = 2'b11;
      tick();
      n_tests++;
      if (bus.chn_trn !== 2'b01) begin
         n_fail++;
         $display("FAIL wd_grant: trn=%b, want 01", bus.chn_trn);
      end
      repeat (2) tick();
      bus.chn_reqep = 2'b10;
      tick();
      n_tests++;
      if (bus.chn_trn !== 2'b00 || timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL wd_gap: trn=%b to=%b, want 00/0", bus.chn_trn, timeout_err);
      end
      repeat (2) tick();
      n_tests++;
      if (bus.chn_trn !== 2'b10 || gnt_idx !== 1'b1) begin
         n_fail++;
         $display("FAIL wd_next: trn=%b idx=%0d, want 10/1", bus.chn_trn, gnt_idx);
      end
      drop_all();
      exp_last = 1;
   endtask

   task automatic test_merge();
      logic [63:0] e_td;
      logic [7:0]  e_rem;
      logic [2:0]  e_st;
      bus.chn_reqep = 2'b01;
      tick();
      n_tests++;
      if (bus.chn_trn !== 2'b01) begin
         n_fail++;
         $display("FAIL mg_grant: trn=%b, want 01", bus.chn_trn);
      end
      bus.chn_drvn = 2'b01;
      for (int b = 0; b < 3; b++) begin
         e_td  = {8'hA5, 24'($urandom), $urandom};
         e_rem = (b == 2) ? 8'($urandom) : 8'h00;
         e_st  = {(b == 0) ? 1'b0 : 1'b1, (b == 2) ? 1'b0 : 1'b1, 1'b0};
         bus.chn_trn_td[0]         = e_td;
         bus.chn_trn_trem_n[0]     = e_rem;
         {bus.chn_trn_tsof_n[0], bus.chn_trn_teof_n[0], bus.chn_trn_tsrc_rdy_n[0]} = e_st;
         #1;
         n_tests++;
         if ({bus.trn_td, bus.trn_trem_n, bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n}
             !== {e_td, e_rem, e_st}) begin
            n_fail++;
            $display("FAIL mg_beat%0d: td=%h rem=%h st=%b, want %h %h %b", b, bus.trn_td,
                     bus.trn_trem_n, {bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n},
                     e_td, e_rem, e_st);
         end
         tick();
      end
      idle_bus();
      drop_all();
      exp_last = 0;
      // Random overlapping buses: merge is a pure OR/AND regardless of grant.
      for (int it = 0; it < 8; it++) begin
         e_td = '0; e_rem = '1; e_st = '1;
         for (int c = 0; c < NCH; c++) begin
            bus.chn_trn_td[c]         = {$urandom, $urandom};
            bus.chn_trn_trem_n[c]     = 8'($urandom);
            bus.chn_trn_tsof_n[c]     = 1'($urandom);
            bus.chn_trn_teof_n[c]     = 1'($urandom);
            bus.chn_trn_tsrc_rdy_n[c] = 1'($urandom);
            e_td  = e_td | bus.chn_trn_td[c];
            e_rem = e_rem & bus.chn_trn_trem_n[c];
            e_st  = e_st & {bus.chn_trn_tsof_n[c], bus.chn_trn_teof_n[c], bus.chn_trn_tsrc_rdy_n[c]};
         end
         #1;
         n_tests++;
         if ({bus.trn_td, bus.trn_trem_n, bus.trn_tsof_n, bus.trn_teof_n, bus.trn_tsrc_rdy_n}
             !== {e_td, e_rem, e_st}) begin
            n_fail++;
            $display("FAIL mg_rand%0d: td=%h rem=%h, want %h %h", it, bus.trn_td,
                     bus.trn_trem_n, e_td, e_rem);
         end
         tick();
      end
      idle_bus();
      tick();
   endtask

   task automatic test_viol();
      bus.chn_reqep = 2'b01;
      tick();
      bus.chn_drvn = 2'b01;
      tick();
      bus.chn_drvn = 2'b11;
      #1;
      n_tests++;
      if (viol_err !== 1'b1 || bus.chn_trn !== 2'b01) begin
         n_fail++;
         $display("FAIL viol_pulse: viol=%b trn=%b, want 1/01", viol_err, bus.chn_trn);
      end
      tick();
      bus.chn_drvn = 2'b01;
      #1;
      n_tests++;
      if (viol_err !== 1'b0 || bus.chn_trn !== 2'b01 || gnt_idx !== 1'b0) begin
         n_fail++;
         $display("FAIL viol_state: viol=%b trn=%b idx=%0d, want 0/01/0",
                  viol_err, bus.chn_trn, gnt_idx);
      end
      bus.chn_drvn  = 2'b00;
      bus.chn_reqep = 2'b00;
      tick();
      bus.chn_drvn = 2'b01;
      #1;
      n_tests++;
      if (viol_err !== 1'b0 || bus.chn_trn !== 2'b00) begin
         n_fail++;
         $display("FAIL viol_tail: viol=%b trn=%b, want 0/00", viol_err, bus.chn_trn);
      end
      tick();
      n_tests++;
      if (viol_err !== 1'b1) begin
         n_fail++;
         $display("FAIL viol_idle: viol=%b, want 1", viol_err);
      end
      drop_all();
      exp_last = 0;
   endtask

   task automatic test_reset_mid();
      bus.chn_reqep = 2'b10;
      tick();
      bus.chn_drvn = 2'b10;
      tick();
      rst_n = 1'b0;
      tick();
      n_tests++;
      if (bus.chn_trn !== 2'b00 || gnt_idx !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_drop: trn=%b idx=%0d, want 00/0", bus.chn_trn, gnt_idx);
      end
      rst_n = 1'b1;
      bus.chn_drvn  = 2'b00;
      bus.chn_reqep = 2'b11;
      tick();
      n_tests++;
      if (bus.chn_trn !== 2'b01 || gnt_idx !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_first: trn=%b idx=%0d, want 01/0", bus.chn_trn, gnt_idx);
      end
      drop_all();
      exp_last = 0;
   endtask

   task automatic test_random();
      logic [NCH-1:0] req;
      logic [NCH-1:0] e_oh;
      int exp, act, cyc, hold, viol_seen;
      viol_seen = 0;
      for (int ep = 0; ep < 24; ep++) begin
         req = NCH'($urandom_range(1, (1 << NCH) - 1));
         exp = model_pick(req, exp_last);
         e_oh = NCH'(1) << exp;
         bus.chn_reqep = req;
         wait_gnt(4, cyc);
         n_tests++;
         if (cyc != 1 || bus.chn_trn !== e_oh || gnt_idx !== IDX_W'(exp)) begin
            n_fail++;
            $display("FAIL rnd%0d_grant: trn=%b idx=%0d lat=%0d, want %b/%0d/1",
                     ep, bus.chn_trn, gnt_idx, cyc, e_oh, exp);
         end
         exp_last = exp;
         act = $urandom_range(0, 2);
         if (act == 0) begin
            hold = $urandom_range(1, 20);
            bus.chn_drvn[exp] = 1'b1;
            repeat (hold) begin
               tick();
               if (viol_err !== 1'b0) viol_seen++;
            end
            n_tests++;
            if (bus.chn_trn !== e_oh || timeout_err !== 1'b0) begin
               n_fail++;
               $display("FAIL rnd%0d_busy: trn=%b to=%b after %0d, want %b/0",
                        ep, bus.chn_trn, timeout_err, hold, e_oh);
            end
            bus.chn_drvn[exp] = 1'b0;
            tick();
         end else if (act == 1) begin
            hold = $urandom_range(0, 10);
            repeat (hold) tick();
            bus.chn_reqep[exp] = 1'b0;
            tick();
         end else begin
            wait_drop(TO_CYC + 4, cyc);
            n_tests++;
            if (cyc != TO_CYC || timeout_err !== 1'b1) begin
               n_fail++;
               $display("FAIL rnd%0d_timeout: cycles=%0d to=%b, want %0d/1",
                        ep, cyc, timeout_err, TO_CYC);
            end
         end
         n_tests++;
         if (bus.chn_trn !== '0 || (act != 2 && timeout_err !== 1'b0)) begin
            n_fail++;
            $display("FAIL rnd%0d_release: trn=%b to=%b act=%0d, want 00", ep,
                     bus.chn_trn, timeout_err, act);
         end
         bus.chn_reqep = '0;
         bus.chn_drvn  = '0;
         tick();
      end
      n_tests++;
      if (viol_seen != 0) begin
         n_fail++;
         $display("FAIL rnd_viol: %0d spurious viol_err cycles, want 0", viol_seen);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      bus.chn_reqep = '0;
      bus.chn_drvn  = '0;
      idle_bus();
      test_reset();
      test_basic();
      test_timeout();
      test_withdraw();
      test_merge();
      test_viol();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

endmodule
